// File: rtl/osd_pkg.sv
// osd_pkg: shared command codes, buffer depth and FSM state types for the OSD command controller
package osd_pkg;
    localparam logic [7:0] CMD_WRITE      = 8'h20;
    localparam logic [7:0] CMD_WRITE_MASK = 8'hF8;
    localparam logic [7:0] CMD_ENA        = 8'h40;
    localparam logic [7:0] CMD_ENA_MASK   = 8'hFE;
    localparam logic [7:0] CMD_CLEAR      = 8'h08;
    localparam int BUF_DEPTH = 2048;
    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;
    typedef enum logic {C_IDLE, C_RUN} clr_state_t;
    function automatic logic is_write(input logic [7:0] c);
        return (c & CMD_WRITE_MASK) == CMD_WRITE;
    endfunction
    function automatic logic is_ena(input logic [7:0] c);
        return (c & CMD_ENA_MASK) == CMD_ENA;
    endfunction
endpackage

// File: rtl/osd_cmd_ctrl_if.sv
// osd_cmd_ctrl_if: SPI pins from the IO controller plus the OSD buffer write port and status
interface osd_cmd_ctrl_if #(parameter int ADDR_W = 11);
    logic              sck;
    logic              ss;
    logic              sdi;
    logic              osd_enable;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              busy;
    modport master (output sck, ss, sdi, input osd_enable, buf_we, buf_addr, buf_wdata, busy);
    modport slave (input sck, ss, sdi, output osd_enable, buf_we, buf_addr, buf_wdata, busy);
endinterface

// File: rtl/osd_sync_edge.sv
// osd_sync_edge: multi-flop synchronizer with one extra stage for rise/fall detection
module osd_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES:0] s;
    // shift the asynchronous input through the chain; the top stage only feeds edge detection
    always_ff @(posedge clk) begin
        s <= reset ? {(STAGES+1){INIT}} : {s[STAGES-1:0], d};
    end
    assign q    = s[STAGES-1];
    assign rise = s[STAGES-1] & ~s[STAGES];
    assign fall = ~s[STAGES-1] & s[STAGES];
endmodule

// File: rtl/osd_cmd_ctrl.sv
// osd_cmd_ctrl: SPI command sequencer owning the OSD buffer write port, arbitrating SPI writes against a clear sweep
module osd_cmd_ctrl
    import osd_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    osd_cmd_ctrl_if.slave bus
);
    logic sck_rise, ss_q, sdi_q;
    logic sck_q_unused, sck_fall_unused, ss_rise_unused, ss_fall_unused, sdi_rise_unused, sdi_fall_unused;
    spi_state_t spi_state, spi_next;
    clr_state_t cstate, cnext;
    logic [2:0] bit_cnt;
    logic [7:0] sbuf, cmd, new_byte, pend_data;
    logic [ADDR_W-1:0] wptr, pend_addr, caddr;
    logic byte_done, cmd_done, wr_byte, clr_start, clr_go, spi_pend;

    osd_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
        .clk(clk), .reset(reset), .d(bus.sck), .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall_unused)
    );
    osd_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
        .clk(clk), .reset(reset), .d(bus.ss), .q(ss_q), .rise(ss_rise_unused), .fall(ss_fall_unused)
    );
    osd_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sdi (
        .clk(clk), .reset(reset), .d(bus.sdi), .q(sdi_q), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    assign new_byte  = {sbuf[6:0], sdi_q};
    assign byte_done = !ss_q && sck_rise && bit_cnt == 3'd7;
    assign cmd_done  = byte_done && spi_state == CMD;
    assign wr_byte   = byte_done && spi_state == DATA && is_write(cmd);
    assign clr_start = cmd_done && new_byte == CMD_CLEAR;
    assign clr_go    = cstate == C_RUN && !spi_pend;
    assign bus.busy  = cstate == C_RUN;

    // next state: ss high always wins; a clear command (re)starts the sweep, which ends after the top address
    always_comb begin
        spi_next = ss_q ? IDLE : spi_state == IDLE ? CMD : cmd_done ? DATA : spi_state;
        cnext    = clr_start ? C_RUN : (clr_go && caddr == '1) ? C_IDLE : cstate;
    end

    // state registers for both FSMs
    always_ff @(posedge clk) begin
        spi_state <= reset ? IDLE : spi_next;
        cstate    <= reset ? C_IDLE : cnext;
    end

    // bit assembly, command decode, line-write pointer and the one-cycle SPI write request
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt        <= '0;
            sbuf           <= '0;
            cmd            <= '0;
            wptr           <= '0;
            spi_pend       <= 1'b0;
            pend_addr      <= '0;
            pend_data      <= '0;
            bus.osd_enable <= 1'b0;
        end else begin
            bit_cnt <= ss_q ? 3'd0 : bit_cnt + 3'(sck_rise);
            if (!ss_q && sck_rise) sbuf <= new_byte;
            if (cmd_done) cmd <= new_byte;
            if (cmd_done && is_ena(new_byte)) bus.osd_enable <= new_byte[0];
            if (cmd_done && is_write(new_byte)) wptr <= ADDR_W'({new_byte[2:0], 8'h00});
            else if (wr_byte) wptr <= wptr + ADDR_W'(1);
            spi_pend <= wr_byte;
            if (wr_byte) begin
                pend_addr <= wptr;
                pend_data <= new_byte;
            end
        end
    end

    // sweep address and the registered write port; a pending SPI byte stalls the sweep for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            caddr         <= '0;
            bus.buf_we    <= 1'b0;
            bus.buf_addr  <= '0;
            bus.buf_wdata <= '0;
        end else begin
            caddr      <= clr_start ? '0 : clr_go ? caddr + ADDR_W'(1) : caddr;
            bus.buf_we <= spi_pend || cstate == C_RUN;
            if (spi_pend || cstate == C_RUN) begin
                bus.buf_addr  <= spi_pend ? pend_addr : caddr;
                bus.buf_wdata <= spi_pend ? pend_data : 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_osd_cmd_ctrl.sv
// tb_osd_cmd_ctrl: random and directed SPI traffic checked against a queue/array model of the buffer port
module tb_osd_cmd_ctrl;
    localparam int DEPTH = 2048;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0, bad = 0, cyc = 0;
    logic [18:0] exp_q[$];
    logic [18:0] wr_log[$];
    logic en_m = 1'b0;
    bit clearing_m = 0, restart_m = 0, sweep_live = 0, quiet = 0;
    int caddr_m = 0, ccount = 0, wptr_m = 0, rise_cyc = 0, last_we_cyc = 0;
    logic busy_d = 1'b0;
    logic [7:0] dq[$];
    logic [7:0] c;
    int n0, hits;

    osd_cmd_ctrl_if bus ();
    osd_cmd_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // every write must be the next expected SPI byte or the next sweep address with 0x00
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.buf_we) begin
                if (exp_q.size() > 0 && {bus.buf_addr, bus.buf_wdata} == exp_q[0]) begin
                    wr_log.push_back(exp_q.pop_front());
                    last_we_cyc = cyc;
                end else if (restart_m && bus.buf_addr == 11'd0 && bus.buf_wdata == 8'd0) begin
                    restart_m = 0;
                    caddr_m = 1;
                    ccount = 1;
                end else begin
                    chk("write_expected", 32'(clearing_m), 1);
                    chk("clear_addr", 32'(bus.buf_addr), caddr_m);
                    chk("clear_data", 32'(bus.buf_wdata), 0);
                    caddr_m = (caddr_m + 1) % DEPTH;
                    ccount++;
                    if (ccount == DEPTH) clearing_m = 0;
                end
            end
            if (busy_d && !bus.busy && sweep_live) begin
                chk("sweep_len", ccount, DEPTH);
                sweep_live = 0;
            end
            if (quiet) begin
                chk("osd_enable", 32'(bus.osd_enable), 32'(en_m));
                chk("busy", 32'(bus.busy), 32'(clearing_m));
            end
            busy_d = bus.busy;
        end
    end

    task automatic model_cmd(input logic [7:0] cm);
        if (cm[7:1] == 7'h20) en_m = cm[0];
        if (cm[7:3] == 5'b00100) wptr_m = int'(cm[2:0]) * 256;
        if (cm == 8'h08) begin
            if (clearing_m) restart_m = 1;
            else begin
                clearing_m = 1;
                caddr_m = 0;
                ccount = 0;
            end
            sweep_live = 1;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.sdi = b[i];
            repeat (4) @(negedge clk);
            bus.sck = 1'b1;
            rise_cyc = cyc;
            repeat (4) @(negedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] cm, input int partial);
        bit wr;
        quiet = 0;
        bus.ss = 1'b0;
        repeat (4) @(negedge clk);
        model_cmd(cm);
        wr = cm[7:3] == 5'b00100;
        spi_byte(cm, 8);
        foreach (dq[i]) begin
            if (wr) begin
                exp_q.push_back({11'(wptr_m), dq[i]});
                wptr_m = (wptr_m + 1) % DEPTH;
            end
            spi_byte(dq[i], 8);
        end
        if (partial > 0) spi_byte(8'h3C, partial);
        repeat (2) @(negedge clk);
        bus.ss = 1'b1;
        repeat (10) @(negedge clk);
        quiet = 1;
        dq.delete();
    endtask

    task automatic wait_clear();
        int n = 0;
        while (clearing_m && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("clear_finished", 32'(clearing_m), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.sck = 1'b0;
        bus.ss = 1'b1;
        bus.sdi = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_osd_enable", 32'(bus.osd_enable), 0);
        chk("rst_buf_we", 32'(bus.buf_we), 0);
        chk("rst_buf_addr", 32'(bus.buf_addr), 0);
        chk("rst_buf_wdata", 32'(bus.buf_wdata), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        quiet = 1;

        n0 = wr_log.size();
        xfer(8'h41, 0);
        chk("ena_on", 32'(bus.osd_enable), 1);
        chk("ena_no_write", wr_log.size() - n0, 0);
        xfer(8'h40, 0);
        chk("ena_off", 32'(bus.osd_enable), 0);

        n0 = wr_log.size();
        dq.push_back(8'hAA);
        dq.push_back(8'h55);
        xfer(8'h23, 0);
        chk("lw_count", wr_log.size() - n0, 2);
        if (wr_log.size() >= n0 + 2) begin
            chk("lw_first", 32'(wr_log[n0]), 32'h300AA);
            chk("lw_second", 32'(wr_log[n0+1]), 32'h30155);
        end
        chk("lw_latency", last_we_cyc - rise_cyc, 4);

        n0 = wr_log.size();
        for (int i = 0; i < 257; i++) dq.push_back(8'($urandom_range(1, 255)));
        xfer(8'h27, 0);
        chk("wrap_count", wr_log.size() - n0, 257);
        chk("wrap_last_addr", 32'(wr_log[wr_log.size()-1][18:8]), 0);
        hits = 0;
        for (int i = n0; i < wr_log.size(); i++) if (wr_log[i][18:8] == 11'h700) hits++;
        chk("wrap_0x700_once", hits, 1);

        n0 = wr_log.size();
        dq.push_back(8'h11);
        xfer(8'h21, 5);
        chk("abort_count", wr_log.size() - n0, 1);
        chk("abort_kept", 32'(wr_log[wr_log.size()-1]), 32'h10011);
        dq.push_back(8'h22);
        xfer(8'h21, 0);
        chk("after_abort", 32'(wr_log[wr_log.size()-1]), 32'h10022);

        xfer(8'h08, 0);
        dq.push_back(8'h5A);
        xfer(8'h20, 0);
        chk("collide_write", 32'(wr_log[wr_log.size()-1]), 32'h0005A);
        chk("collide_busy", 32'(bus.busy), 1);
        xfer(8'h08, 0);
        chk("restart_seen", 32'(restart_m), 0);
        wait_clear();
        chk("clear_done_busy", 32'(bus.busy), 0);

        xfer(8'h41, 0);
        xfer(8'h08, 0);
        for (int n = 0; n < 5000 && ccount < 256; n++) @(negedge clk);
        chk("reach_0x100", 32'(ccount >= 256), 1);
        reset = 1'b1;
        clearing_m = 0;
        sweep_live = 0;
        restart_m = 0;
        en_m = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_enable", 32'(bus.osd_enable), 0);
        xfer(8'h08, 0);
        wait_clear();

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0: c = 8'h40 | 8'($urandom_range(0, 1));
                1, 2: c = 8'h20 | 8'($urandom_range(0, 7));
                default: do c = 8'($urandom_range(0, 255)); while (c == 8'h08 || c[7:3] == 5'b00100 || c[7:1] == 7'h20);
            endcase
            for (int i = $urandom_range(0, 4); i > 0; i--) dq.push_back(8'($urandom_range(1, 255)));
            xfer(c, $urandom_range(0, 7));
        end

        chk("queue_empty", exp_q.size(), 0);
        chk("no_clear_left", 32'(clearing_m), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
